fft_sdf_ctrl: RTL and testbench
===============================

// Module: fft_sdf_ctrl
// PURPOSE
// - Sequencer for a radix-2 single-delay-feedback FFT pipeline of STAGES butterfly stages.
// - Stage s uses delay D_s = N>>(s+1) and shares one ROM twiddle port.
// - Drives each stage's shift enable, butterfly mode and twiddle ROM index from one frame counter.
// - Zero-fills to drain the last frame, and tags output samples with valid, index and frame-done.
// PARAMETERS
// - N       16         FFT size, power of two, 4..1024
// - STAGES  $clog2(N)  number of butterfly stages; fixed by N, not overridable
// - L       N-1+STAGES pipeline latency in enabled cycles; derived localparam
// PORTS
// - Clk        in   1            rising-edge clock
// - Reset      in   1            synchronous, active-high
// - In_valid   in   1            input sample present this cycle
// - Flush      in   1            pulse: drain pipeline with zero samples
// - Stage_en   out  1            shift enable to all stages (pipeline advances)
// - Zero_ins   out  1            datapath substitutes 0+0j for the input sample
// - Mode       out  STAGES       Mode[s]=1: stage s fills delay line (pass-through, twiddle 1)
// - Rom_idx    out  STAGES*STAGES  stage s twiddle index at [s*STAGES +: STAGES]
// - Out_valid  out  1            pipeline output holds a real sample
// - Out_idx    out  STAGES       frequency index of the current output sample
// - Frame_done out  1            1-cycle pulse with the last output sample of a frame
// - Busy       out  1            state != IDLE
// BEHAVIOUR
// - Reset: state IDLE; all counters 0; every output 0. Reset mid-frame discards the frame with no Frame_done.
// - FSM states:
//   - IDLE: Stage_en=0. In_valid -> RUN. Flush is ignored in IDLE.
//   - RUN: Stage_en=In_valid, Zero_ins=0.
//     - In_valid=0: pipeline and all counters hold; outputs hold.
//     - Flush=1 in RUN: -> FLUSH, taking effect on the next cycle.
//     - Flush and In_valid both 1 in the same cycle: the sample is accepted first.
//   - FLUSH: Stage_en=1, Zero_ins=1 every cycle for exactly L cycles.
//     - The zeros are not counted as frame samples.
//     - After L cycles -> IDLE, all counters cleared.
//     - In_valid is ignored during FLUSH.
// - Counters:
//   - tot = enabled-cycle counter, width STAGES+1, wraps.
//   - Stage s local count c_s = (tot - O_s) mod N, with O_0=0 and O_{s+1} = O_s + D_s + 1.
//     The +1 is the per-stage output register.
// - Per-stage controls:
//   - Mode[s] = ~c_s bit log2(D_s): 1 during the first D_s samples of each 2*D_s block.
//   - Rom_idx[s] = (c_s mod D_s) << s. Width STAGES; the shift never overflows since (D_s-1)<<s < N/2.
//   - Registered: values apply to the stage cycle in which the counter takes that value.
// - Output tagging:
//   - Out_valid rises on the enabled cycle after L enabled cycles from the first accepted sample.
//   - Out_valid stays 1 while real samples remain, and deasserts when zero-fill reaches the output.
//   - Out_idx = output-side counter o = (tot - L) mod N, with the index transform given under CONFIGURATION.
//   - Frame_done = Out_valid & (o == N-1) & Stage_en.
// - Stalls and back-to-back frames:
//   - Stall is global: outputs are meaningful only when Stage_en=1.
//   - Back-to-back frames need no gap; the counter wrap starts the next frame.
// CONFIGURATION
// - FFT_BITREV_EN defined: Out_idx = bit-reverse(o), the true frequency bin of SDF output order.
// - FFT_BITREV_EN undefined: Out_idx = o, natural arrival order. A downstream reorder buffer maps the index.
// TESTING
// - N=16, STAGES=4, L=19 unless stated.
// - Reset 3 cycles, then idle 5 cycles
//   -> all outputs 0, Busy=0, Stage_en=0.
// - 16 contiguous In_valid, then Flush pulse
//   -> Busy=1; Mode[0]=1 for inputs 0..7 and 0 for 8..15; Rom_idx[0]=0..7 over inputs 8..15.
//   -> 19 FLUSH cycles with Zero_ins=1; Out_valid for 16 cycles; Frame_done once; then IDLE.
// - In_valid toggled 1,0,1,0 during a frame
//   -> Stage_en follows In_valid; Mode, Rom_idx and tot hold on 0 cycles; output order unchanged.
// - Two frames back-to-back (32 inputs), then Flush
//   -> 32 Out_valid cycles, Frame_done at output samples 15 and 31, Out_idx wraps 15 -> 0.
// - Flush and In_valid both 1 on input 5, then Reset asserted at FLUSH cycle 4
//   -> sample 5 accepted, FLUSH entered; Reset returns IDLE next cycle, no Frame_done.
// - Build with FFT_BITREV_EN
//   -> Out_idx sequence 0,8,4,12,2,10,... ; without the macro -> 0,1,2,3,...

Source files
------------

// File: rtl/fft_sdf_ctrl.sv
// Sequencer for a radix-2 single-delay-feedback FFT pipeline: stage shift enable, butterfly mode, twiddle ROM index, output tagging.
// Latency: Mode/Rom_idx/Out_* are registered; Stage_en/Zero_ins/Busy/Frame_done are combinational from state and i_in_valid.
// Backpressure: o_stage_en doubles as the input accept; i_in_valid low in RUN stalls the whole pipeline, and counters and outputs hold.
//
// Optional feature: define FFT_BITREV_EN to report bit-reversed (true frequency bin) output indices.
// Ports: i_clk, i_reset (sync, active-high), i_in_valid, i_flush -> o_stage_en, o_zero_ins, o_mode[STAGES],
//        o_rom_idx[STAGES*STAGES] (stage s at [s*STAGES +: STAGES]), o_out_valid, o_out_idx[STAGES], o_frame_done, o_busy.
module fft_sdf_ctrl #(
    parameter int N = 16
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_in_valid,
    input  logic                           i_flush,
    output logic                           o_stage_en,
    output logic                           o_zero_ins,
    output logic [$clog2(N)-1:0]           o_mode,
    output logic [$clog2(N)*$clog2(N)-1:0] o_rom_idx,
    output logic                           o_out_valid,
    output logic [$clog2(N)-1:0]           o_out_idx,
    output logic                           o_frame_done,
    output logic                           o_busy
);
    localparam int STAGES = $clog2(N);
    localparam int L      = N - 1 + STAGES;
    localparam int TW     = STAGES + 1;
    localparam int FW     = $clog2(L + 1);
    localparam int CW     = $clog2(L);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                   r_state, w_state_nxt;
    logic [TW-1:0]            r_tot, w_tot_nxt;
    logic [FW-1:0]            r_fill, w_fill_nxt;
    logic [CW-1:0]            r_fcnt;
    logic [STAGES-1:0]        r_mode, w_mode_nxt;
    logic [STAGES*STAGES-1:0] r_rom, w_rom_nxt;
    logic                     r_out_valid;
    logic [STAGES-1:0]        r_o, w_o_nxt;
    logic [STAGES-1:0]        w_c;
    logic                     w_stage_en, w_zero_ins, w_busy;

    // Offset of stage s: sum of upstream delay lines plus one output register each.
    function automatic int stage_off(input int s);
        int off;
        off = 0;
        for (int k = 0; k < s; k++) off = off + (N >> (k + 1)) + 1;
        return off;
    endfunction

    function automatic logic [STAGES-1:0] bitrev(input logic [STAGES-1:0] x);
        logic [STAGES-1:0] r;
        r = '0;
        for (int b = 0; b < STAGES; b++) r[b] = x[STAGES-1-b];
        return r;
    endfunction

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state logic; Flush is only honoured in RUN, and the sample offered
    // alongside it is still accepted because Stage_en follows In_valid in RUN.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_in_valid) w_state_nxt = S_RUN;
            S_RUN:   if (i_flush) w_state_nxt = S_FLUSH;
            S_FLUSH: if (r_fcnt == CW'(L - 1)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_stage_en = 1'b0;
        w_zero_ins = 1'b0;
        w_busy     = 1'b0;
        case (r_state)
            S_RUN: begin
                w_stage_en = i_in_valid;
                w_busy     = 1'b1;
            end
            S_FLUSH: begin
                w_stage_en = 1'b1;
                w_zero_ins = 1'b1;
                w_busy     = 1'b1;
            end
            default: ;
        endcase
    end

    // Controls are computed from the counter value the pipeline will hold
    // next, so the registered outputs line up with that stage cycle.
    always_comb begin
        w_tot_nxt  = r_tot + TW'(w_stage_en);
        w_fill_nxt = (r_fill == FW'(L)) ? r_fill : r_fill + FW'(w_stage_en);
        w_o_nxt    = STAGES'(w_tot_nxt - TW'(L));
        w_mode_nxt = '0;
        w_rom_nxt  = '0;
        w_c        = '0;
        for (int s = 0; s < STAGES; s++) begin
            w_c = STAGES'(w_tot_nxt - TW'(stage_off(s)));
            w_mode_nxt[s] = ~w_c[STAGES-1-s];
            w_rom_nxt[s*STAGES +: STAGES] = (w_c & STAGES'((N >> (s + 1)) - 1)) << s;
        end
    end

    // Counters and registered controls; everything clears on the way back to IDLE.
    always_ff @(posedge i_clk) begin
        if (i_reset || w_state_nxt == S_IDLE) begin
            r_tot       <= '0;
            r_fill      <= '0;
            r_mode      <= '0;
            r_rom       <= '0;
            r_o         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_tot       <= w_tot_nxt;
            r_fill      <= w_fill_nxt;
            r_mode      <= w_mode_nxt;
            r_rom       <= w_rom_nxt;
            r_o         <= w_o_nxt;
            // Fill saturates at L: once the first sample has crossed the
            // pipeline every later output is real until the flush ends.
            r_out_valid <= (w_fill_nxt == FW'(L));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || r_state != S_FLUSH) r_fcnt <= '0;
        else                               r_fcnt <= r_fcnt + CW'(1);
    end

    assign o_stage_en   = w_stage_en;
    assign o_zero_ins   = w_zero_ins;
    assign o_busy       = w_busy;
    assign o_mode       = r_mode;
    assign o_rom_idx    = r_rom;
    assign o_out_valid  = r_out_valid;
    assign o_frame_done = r_out_valid & (r_o == STAGES'(N - 1)) & w_stage_en;
`ifdef FFT_BITREV_EN
    assign o_out_idx    = bitrev(r_o);
`else
    assign o_out_idx    = r_o;
`endif

endmodule

// File: tb/tb_fft_sdf_ctrl.sv
module tb_fft_sdf_ctrl;
    localparam int N   = 16;
    localparam int STG = 4;
    localparam int L   = N - 1 + STG;

    logic               clk = 1'b0;
    logic               reset, in_valid, flush;
    logic               stage_en, zero_ins, out_valid, frame_done, busy;
    logic [STG-1:0]     mode, out_idx;
    logic [STG*STG-1:0] rom_idx;

    int checks = 0;
    int errors = 0;

    // Behavioural model: phase 0 idle, 1 run, 2 flush; t = enabled cycles in
    // this frame, s = real samples accepted, fc = flush cycles done.
    int m_phase = 0, m_t = 0, m_s = 0, m_fc = 0;
    int n_out, n_fd, n_zero, n_acc;

    fft_sdf_ctrl #(.N(N)) dut (
        .i_clk(clk), .i_reset(reset), .i_in_valid(in_valid), .i_flush(flush),
        .o_stage_en(stage_en), .o_zero_ins(zero_ins), .o_mode(mode), .o_rom_idx(rom_idx),
        .o_out_valid(out_valid), .o_out_idx(out_idx), .o_frame_done(frame_done), .o_busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int modn(input int x);
        return ((x % N) + N) % N;
    endfunction

    function automatic int brev(input int x);
        int r;
        r = 0;
        for (int b = 0; b < STG; b++) if (((x >> b) & 1) == 1) r = r + (1 << (STG - 1 - b));
        return r;
    endfunction

    function automatic int bin_of(input int o);
`ifdef FFT_BITREV_EN
        return brev(o);
`else
        return o;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic f, input logic r);
        logic               en_e, ov_e, fd_e;
        logic [STG-1:0]     mode_e;
        logic [STG*STG-1:0] rom_e;
        int                 o, off, d, c, oidx_e;
        @(posedge clk);
        #1;
        in_valid = v;
        flush    = f;
        reset    = r;
        @(negedge clk);
        en_e   = (m_phase == 1) ? v : (m_phase == 2);
        mode_e = '0;
        rom_e  = '0;
        oidx_e = 0;
        ov_e   = 1'b0;
        o      = modn(m_t - L);
        if (m_phase != 0) begin
            off = 0;
            for (int s = 0; s < STG; s++) begin
                d = N >> (s + 1);
                c = modn(m_t - off);
                mode_e[s] = ((c % (2 * d)) < d);
                rom_e[s*STG +: STG] = STG'((c % d) << s);
                off = off + d + 1;
            end
            ov_e   = (m_t >= L) && (m_t - L < m_s);
            oidx_e = bin_of(o);
        end
        fd_e = ov_e && (o == N - 1) && en_e;
        chk("stage_en",   stage_en,   en_e);
        chk("zero_ins",   zero_ins,   m_phase == 2);
        chk("busy",       busy,       m_phase != 0);
        chk("mode",       mode,       mode_e);
        chk("rom_idx",    rom_idx,    rom_e);
        chk("out_valid",  out_valid,  ov_e);
        chk("out_idx",    out_idx,    oidx_e);
        chk("frame_done", frame_done, fd_e);
        // Output order as seen downstream, independent of the tot bookkeeping.
        if (out_valid && stage_en) begin
            chk("out_order", out_idx, bin_of(n_out % N));
            n_out++;
        end
        if (frame_done) n_fd++;
        if (zero_ins) n_zero++;
        if (stage_en && !zero_ins) n_acc++;
        // Advance the model to the state after the coming clock edge.
        if (r) begin
            m_phase = 0; m_t = 0; m_s = 0; m_fc = 0;
        end else if (m_phase == 0) begin
            if (v) begin m_phase = 1; m_t = 0; m_s = 0; end
        end else if (m_phase == 1) begin
            if (v) begin m_t++; m_s++; end
            if (f) begin m_phase = 2; m_fc = 0; end
        end else begin
            m_t++;
            m_fc++;
            if (m_fc == L) begin m_phase = 0; m_t = 0; m_s = 0; end
        end
    endtask

    // pat: 0 contiguous, 1 alternating 1/0, 2 random with ~30% stalls
    task automatic feed(input int n, input int pat);
        int   g;
        logic v;
        g = 0;
        while (m_s < n && g < 2000) begin
            if (pat == 0)      v = 1'b1;
            else if (pat == 1) v = (g % 2 == 0);
            else               v = ($urandom_range(99) >= 30);
            step(v, 1'b0, 1'b0);
            g++;
        end
        chk("feed_acc", n_acc, n);
    endtask

    task automatic clear_stats();
        n_out = 0; n_fd = 0; n_zero = 0; n_acc = 0;
    endtask

    task automatic run_frame(input int n, input int pat, input bit coincide);
        int   cyc;
        logic rv;
        clear_stats();
        if (coincide) begin
            feed(n - 1, pat);
            step(1'b1, 1'b1, 1'b0);
        end else begin
            feed(n, pat);
            step(1'b0, 1'b1, 1'b0);
        end
        cyc = 0;
        while (busy && cyc < 4 * L) begin
            // In_valid is noise during FLUSH and must be ignored.
            rv = (m_phase == 2) ? ($urandom_range(1) == 1) : 1'b0;
            step(rv, 1'b0, 1'b0);
            cyc++;
        end
        chk("drain_bound", busy, 1'b0);
        chk("n_acc",  n_acc,  n);
        chk("n_out",  n_out,  n);
        chk("n_fd",   n_fd,   n / N);
        chk("n_zero", n_zero, L);
        step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
        clear_stats();
        repeat (3) step(1'b0, 1'b0, 1'b1);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);          // Flush in IDLE is ignored
        step(1'b0, 1'b0, 1'b0);

        run_frame(16, 0, 1'b0);          // one contiguous frame
        run_frame(16, 1, 1'b0);          // In_valid toggling
        run_frame(32, 0, 1'b0);          // two frames back-to-back

        // Flush coincident with input 5, then reset at FLUSH cycle 4.
        clear_stats();
        feed(5, 0);
        step(1'b1, 1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("rst_acc",  n_acc, 6);
        chk("rst_fd",   n_fd, 0);
        chk("rst_busy", busy, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 5; i++) begin
            int n;
            n = $urandom_range(40, 2);
            run_frame(n, 2, ($urandom_range(1) == 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
